// File: rtl/ammrv_arb_2to1.sv
// Two-master to one-slave Avalon-MM arbiter with pipelined-read return steering.
// Define AMMRV_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties); default is round-robin.
module ammrv_arb_2to1 #(
    parameter int P_LOG2PEND = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] s0_address,
    input  logic [3:0]  s0_byteenable,
    input  logic [31:0] s0_writedata,
    input  logic        s0_read,
    input  logic        s0_write,
    output logic        s0_waitrequest,
    output logic [31:0] s0_readdata,
    output logic        s0_readdatavalid,
    input  logic [31:0] s1_address,
    input  logic [3:0]  s1_byteenable,
    input  logic [31:0] s1_writedata,
    input  logic        s1_read,
    input  logic        s1_write,
    output logic        s1_waitrequest,
    output logic [31:0] s1_readdata,
    output logic        s1_readdatavalid,
    output logic [31:0] m_address,
    output logic [3:0]  m_byteenable,
    output logic [31:0] m_writedata,
    output logic        m_read,
    output logic        m_write,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic        err_unexp_rdv
);

    localparam int DEPTH = 1 << P_LOG2PEND;
    localparam logic [P_LOG2PEND:0]   FULL_CNT = (P_LOG2PEND+1)'(DEPTH);
    localparam logic [P_LOG2PEND:0]   CNT_ONE  = (P_LOG2PEND+1)'(1);
    localparam logic [P_LOG2PEND-1:0] PTR_ONE  = P_LOG2PEND'(1);

    logic                  lock_q, lock_d;
    logic                  locked_id_q, locked_id_d;
    logic [DEPTH-1:0]      fifo_q, fifo_d;
    logic [P_LOG2PEND-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [P_LOG2PEND:0]   count_q, count_d;
    logic                  err_q, err_d;
`ifndef AMMRV_ARB_FIXED_PRIO_EN
    logic                  last_winner_q, last_winner_d;
`endif

    logic req0, req1, gnt_vld, gnt_id, sel;
    logic g_read, g_write, rd_block, stall_g;
    logic m_read_int, accept, push, pop, empty, head;

    assign req0 = s0_read | s0_write;
    assign req1 = s1_read | s1_write;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (lock_q) begin
            gnt_vld = 1'b1;
            gnt_id  = locked_id_q;
        end else if (req0 && req1) begin
            gnt_vld = 1'b1;
`ifdef AMMRV_ARB_FIXED_PRIO_EN
            gnt_id  = 1'b0;
`else
            gnt_id  = ~last_winner_q;
`endif
        end else if (req0) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end else if (req1) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    // With no grant the mux parks on master 0.
    assign sel        = gnt_vld & gnt_id;
    assign g_read     = gnt_vld & (sel ? s1_read  : s0_read);
    assign g_write    = gnt_vld & (sel ? s1_write : s0_write);
    assign rd_block   = (count_q == FULL_CNT);
    assign m_read_int = g_read & ~rd_block;
    assign stall_g    = m_waitrequest | (g_read & rd_block);
    assign accept     = (m_read_int | g_write) & ~m_waitrequest;

    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];
    assign push  = accept & m_read_int;
    assign pop   = m_readdatavalid & ~empty;

    // Reset only gates the outputs so flop inputs stay free of the async reset net.
    assign m_address      = sel ? s1_address    : s0_address;
    assign m_byteenable   = sel ? s1_byteenable : s0_byteenable;
    assign m_writedata    = sel ? s1_writedata  : s0_writedata;
    assign m_read         = m_read_int & reset_n;
    assign m_write        = g_write & reset_n;
    assign s0_waitrequest = ~(gnt_vld & ~sel) | stall_g | ~reset_n;
    assign s1_waitrequest = ~(gnt_vld &  sel) | stall_g | ~reset_n;

    assign s0_readdatavalid = pop & ~head;
    assign s1_readdatavalid = pop &  head;
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign err_unexp_rdv    = err_q;

    always_comb begin
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if ((g_read | g_write) && stall_g) begin
            lock_d      = 1'b1;
            locked_id_d = sel;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        err_d = err_q | (m_readdatavalid & empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q      <= 1'b0;
            locked_id_q <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

`ifndef AMMRV_ARB_FIXED_PRIO_EN
    assign last_winner_d = accept ? sel : last_winner_q;

    // Starting at 1 lets master 0 win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_winner_q <= 1'b1;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end
`endif

endmodule

// File: tb/tb_ammrv_arb_2to1.sv
// Bench for ammrv_arb_2to1: vector table, directed read/lock/reset sequences, random run vs queue model.
module tb_ammrv_arb_2to1;

    localparam int LOG2  = 2;
    localparam int DEPTH = 1 << LOG2;
    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;

    logic        clk;
    logic        reset_n;
    logic [31:0] s0_address, s0_writedata, s0_readdata;
    logic [3:0]  s0_byteenable;
    logic        s0_read, s0_write, s0_waitrequest, s0_readdatavalid;
    logic [31:0] s1_address, s1_writedata, s1_readdata;
    logic [3:0]  s1_byteenable;
    logic        s1_read, s1_write, s1_waitrequest, s1_readdatavalid;
    logic [31:0] m_address, m_writedata, m_readdata;
    logic [3:0]  m_byteenable;
    logic        m_read, m_write, m_waitrequest, m_readdatavalid;
    logic        err_unexp_rdv;

    int checks = 0;
    int errors = 0;

    ammrv_arb_2to1 #(.P_LOG2PEND(LOG2)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
        .s0_read(s0_read), .s0_write(s0_write), .s0_waitrequest(s0_waitrequest),
        .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_read(s1_read), .s1_write(s1_write), .s1_waitrequest(s1_waitrequest),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .err_unexp_rdv(err_unexp_rdv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r0, input logic w0, input logic r1, input logic w1,
                       input logic mw, input logic rdv, input logic [31:0] rdata);
        s0_read = r0; s0_write = w0; s1_read = r1; s1_write = w1;
        m_waitrequest = mw; m_readdatavalid = rdv; m_readdata = rdata;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        chk("rst_m_read", m_read, 1'b0);
        chk("rst_m_write", m_write, 1'b0);
        chk("rst_s0_wait", s0_waitrequest, 1'b1);
        chk("rst_s1_wait", s1_waitrequest, 1'b1);
        chk("rst_err", err_unexp_rdv, 1'b0);
        next_cyc();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset_n = 1'b1;
    endtask

    // Reference model: outstanding reads as a queue of master ids plus the held grant.
    bit   mq[$];
    int   m_lw;
    bit   m_lock;
    int   m_lid;
    bit   m_err;
    int   e_g;
    logic e_mr, e_mw, e_wr0, e_wr1, e_rdv0, e_rdv1, e_pres;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;

    task automatic model_reset();
        mq.delete();
        m_lw = 1; m_lock = 1'b0; m_lid = 0; m_err = 1'b0;
    endtask

    task automatic model_eval();
        bit q0, q1, full, grd, gwr, stall;
        q0 = s0_read || s0_write;
        q1 = s1_read || s1_write;
        e_g = -1;
        if (m_lock) e_g = m_lid;
`ifdef AMMRV_ARB_FIXED_PRIO_EN
        else if (q0 && q1) e_g = 0;
`else
        else if (q0 && q1) e_g = (m_lw == 0) ? 1 : 0;
`endif
        else if (q0) e_g = 0;
        else if (q1) e_g = 1;
        full   = (mq.size() == DEPTH);
        grd    = (e_g == 0) ? s0_read  : (e_g == 1) ? s1_read  : 1'b0;
        gwr    = (e_g == 0) ? s0_write : (e_g == 1) ? s1_write : 1'b0;
        e_pres = grd || gwr;
        e_mr   = grd && !full;
        e_mw   = gwr;
        stall  = m_waitrequest || (grd && full);
        e_wr0  = (e_g != 0) || stall;
        e_wr1  = (e_g != 1) || stall;
        e_addr = (e_g == 1) ? s1_address    : s0_address;
        e_be   = (e_g == 1) ? s1_byteenable : s0_byteenable;
        e_wd   = (e_g == 1) ? s1_writedata  : s0_writedata;
        e_rdv0 = m_readdatavalid && mq.size() > 0 && mq[0] == 1'b0;
        e_rdv1 = m_readdatavalid && mq.size() > 0 && mq[0] == 1'b1;
    endtask

    task automatic model_commit();
        bit acc, dummy;
        acc = (e_mr || e_mw) && !m_waitrequest;
        if (m_readdatavalid) begin
            if (mq.size() > 0) dummy = mq.pop_front();
            else m_err = 1'b1;
        end
        if (acc) begin
            m_lock = 1'b0;
            m_lw   = e_g;
            if (e_mr) mq.push_back(e_g[0]);
        end else if (e_pres) begin
            m_lock = 1'b1;
            m_lid  = e_g;
        end
    endtask

    typedef struct {
        logic w0, w1, mw;
        logic ew, ewr0, ewr1;
        logic g;
    } vec_t;
    vec_t tbl[10];

    bit          act[2], isrd[2];
    logic [31:0] rad[2], rwd[2];
    logic [3:0]  rbe[2];
    int          slv_cnt;

    initial begin
        reset_n = 1'b0;
        s0_address = A0; s0_byteenable = 4'hF; s0_writedata = 32'hD0D0_0000;
        s1_address = A1; s1_byteenable = 4'h3; s1_writedata = 32'hD1D1_1111;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef AMMRV_ARB_FIXED_PRIO_EN
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
        tbl[2] = tbl[0];
        tbl[3] = tbl[1];
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6] = tbl[5];
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drv(1'b0, tbl[i].w0, 1'b0, tbl[i].w1, tbl[i].mw, 1'b0, 32'h0);
            @(negedge clk);
            chk($sformatf("tbl%0d_m_write", i), m_write, tbl[i].ew);
            chk($sformatf("tbl%0d_m_read", i), m_read, 1'b0);
            chk($sformatf("tbl%0d_s0_wait", i), s0_waitrequest, tbl[i].ewr0);
            chk($sformatf("tbl%0d_s1_wait", i), s1_waitrequest, tbl[i].ewr1);
            chk($sformatf("tbl%0d_m_addr", i), m_address, tbl[i].g ? A1 : A0);
            next_cyc();
        end

        // Interleaved reads 0,1,1,0 then in-order return A,B,C,D.
        do_reset();
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
        chk("rd1_m_read", m_read, 1'b1); chk("rd1_s0_wait", s0_waitrequest, 1'b0); chk("rd1_addr", m_address, A0);
        next_cyc();
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
        chk("rd2_m_read", m_read, 1'b1); chk("rd2_s1_wait", s1_waitrequest, 1'b0); chk("rd2_addr", m_address, A1);
        next_cyc();
        @(negedge clk);
        chk("rd3_m_read", m_read, 1'b1); chk("rd3_s1_wait", s1_waitrequest, 1'b0);
        next_cyc();
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
        chk("rd4_m_read", m_read, 1'b1); chk("rd4_s0_wait", s0_waitrequest, 1'b0);
        next_cyc();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_000A); @(negedge clk);
        chk("retA_s0", s0_readdatavalid, 1'b1); chk("retA_s1", s1_readdatavalid, 1'b0); chk("retA_data", s0_readdata, 32'hAAAA_000A);
        next_cyc();
        m_readdata = 32'hBBBB_000B; @(negedge clk);
        chk("retB_s0", s0_readdatavalid, 1'b0); chk("retB_s1", s1_readdatavalid, 1'b1); chk("retB_data", s1_readdata, 32'hBBBB_000B);
        next_cyc();
        m_readdata = 32'hCCCC_000C; @(negedge clk);
        chk("retC_s0", s0_readdatavalid, 1'b0); chk("retC_s1", s1_readdatavalid, 1'b1);
        next_cyc();
        m_readdata = 32'hDDDD_000D; @(negedge clk);
        chk("retD_s0", s0_readdatavalid, 1'b1); chk("retD_s1", s1_readdatavalid, 1'b0); chk("retD_data", s0_readdata, 32'hDDDD_000D);
        next_cyc();
        // FIFO now empty: a further pulse is unexpected.
        m_readdata = 32'hEEEE_000E; @(negedge clk);
        chk("unexp_s0", s0_readdatavalid, 1'b0); chk("unexp_s1", s1_readdatavalid, 1'b0); chk("unexp_err_pre", err_unexp_rdv, 1'b0);
        next_cyc();
        m_readdatavalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("unexp_err_sticky%0d", k), err_unexp_rdv, 1'b1);
            next_cyc();
        end

        // FIFO full: fifth read stalls, holds grant against master 1, issues the cycle after the pop.
        do_reset();
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            chk($sformatf("fill%0d_m_read", k), m_read, 1'b1);
            chk($sformatf("fill%0d_s0_wait", k), s0_waitrequest, 1'b0);
            next_cyc();
        end
        @(negedge clk);
        chk("full_m_read", m_read, 1'b0); chk("full_s0_wait", s0_waitrequest, 1'b1);
        next_cyc();
        s1_write = 1'b1; @(negedge clk);
        chk("lock_m_read", m_read, 1'b0); chk("lock_m_write", m_write, 1'b0);
        chk("lock_s0_wait", s0_waitrequest, 1'b1); chk("lock_s1_wait", s1_waitrequest, 1'b1);
        next_cyc();
        m_readdatavalid = 1'b1; m_readdata = 32'h1234_5678; @(negedge clk);
        chk("pop_s0_rdv", s0_readdatavalid, 1'b1); chk("pop_m_read", m_read, 1'b0); chk("pop_s0_wait", s0_waitrequest, 1'b1);
        next_cyc();
        m_readdatavalid = 1'b0; @(negedge clk);
        chk("after_pop_m_read", m_read, 1'b1); chk("after_pop_s0_wait", s0_waitrequest, 1'b0);
        chk("after_pop_m_write", m_write, 1'b0); chk("after_pop_s1_wait", s1_waitrequest, 1'b1);
        next_cyc();
        s0_read = 1'b0; @(negedge clk);
        chk("w1_m_write", m_write, 1'b1); chk("w1_s1_wait", s1_waitrequest, 1'b0); chk("w1_addr", m_address, A1);
        next_cyc();

        // Async reset with reads outstanding; later returns are unexpected.
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_m_read", m_read, 1'b0); chk("arst_s0_wait", s0_waitrequest, 1'b1);
        chk("arst_s1_wait", s1_waitrequest, 1'b1); chk("arst_err", err_unexp_rdv, 1'b0);
        next_cyc();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset_n = 1'b1;
        next_cyc();
        m_readdatavalid = 1'b1; @(negedge clk);
        chk("post_rst_s0_rdv", s0_readdatavalid, 1'b0); chk("post_rst_s1_rdv", s1_readdatavalid, 1'b0);
        next_cyc();
        m_readdatavalid = 1'b0; @(negedge clk);
        chk("post_rst_err", err_unexp_rdv, 1'b1);
        next_cyc();

        // Randomized traffic against the queue model.
        do_reset();
        model_reset();
        slv_cnt = 0;
        act[0] = 1'b0; act[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 99) < 55) begin
                    act[m]  = 1'b1;
                    isrd[m] = $urandom_range(0, 1) == 1;
                    rad[m]  = $urandom;
                    rwd[m]  = $urandom;
                    rbe[m]  = 4'($urandom);
                end
            end
            s0_read = act[0] && isrd[0]; s0_write = act[0] && !isrd[0];
            s1_read = act[1] && isrd[1]; s1_write = act[1] && !isrd[1];
            s0_address = rad[0]; s0_writedata = rwd[0]; s0_byteenable = rbe[0];
            s1_address = rad[1]; s1_writedata = rwd[1]; s1_byteenable = rbe[1];
            m_waitrequest   = $urandom_range(0, 99) < 30;
            m_readdatavalid = slv_cnt > 0 && $urandom_range(0, 99) < 40;
            m_readdata      = $urandom;
            model_eval();
            @(negedge clk);
            chk("rnd_m_read", m_read, e_mr);
            chk("rnd_m_write", m_write, e_mw);
            chk("rnd_s0_wait", s0_waitrequest, e_wr0);
            chk("rnd_s1_wait", s1_waitrequest, e_wr1);
            chk("rnd_s0_rdv", s0_readdatavalid, e_rdv0);
            chk("rnd_s1_rdv", s1_readdatavalid, e_rdv1);
            chk("rnd_err", err_unexp_rdv, m_err);
            if (e_g >= 0) begin
                chk("rnd_m_addr", m_address, e_addr);
                chk("rnd_m_be", m_byteenable, e_be);
                chk("rnd_m_wd", m_writedata, e_wd);
            end
            if (e_rdv0) chk("rnd_s0_data", s0_readdata, m_readdata);
            if (e_rdv1) chk("rnd_s1_data", s1_readdata, m_readdata);
            if (m_readdatavalid) slv_cnt--;
            if (e_mr && !m_waitrequest) slv_cnt++;
            if (act[0] && !e_wr0) act[0] = 1'b0;
            if (act[1] && !e_wr1) act[1] = 1'b0;
            model_commit();
            next_cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
